// File: rtl/pcm_tdm_sched.sv
// TDM frame scheduler around a single shared A-law encoder.
// Each channel has a one-entry sample buffer. When a channel's slot starts, the
// buffered sample is compressed and loaded for serial transmission. Slot 0 always
// carries the frame alignment word.

// 13-bit two's complement linear sample -> 8-bit A-law code (purely combinational).
module pcm_alaw (
    input  logic [12:0] lin,
    output logic [7:0]  code
);
    logic        neg;
    logic [11:0] mag;
    logic [2:0]  seg;
    logic [3:0]  shamt;
    logic [3:0]  mant;

    // Segment is the position of the leading one; mantissa is the next four bits.
    // Negative inputs use the one's complement, so -1 maps to magnitude 0.
    always_comb begin
        neg = lin[12];
        mag = neg ? ~lin[11:0] : lin[11:0];
        seg = 3'd0;
        for (int i = 5; i <= 11; i++) begin
            if (mag[i]) seg = 3'(i - 4);
        end
        shamt = (seg == 3'd0) ? 4'd1 : {1'b0, seg};
        mant  = 4'(mag >> shamt);
        code  = {~neg, seg, mant} ^ 8'h55;
    end
endmodule

module pcm_tdm_sched #(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] FAS_WORD  = 8'h1B,
    parameter logic [7:0] IDLE_CODE = 8'hD5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bit_tick,
    input  logic [13*NUM_CH-1:0]  ch_sample,
    input  logic [NUM_CH-1:0]     ch_valid,
    output logic [NUM_CH-1:0]     ch_ready,
    output logic                  tx_bit,
    output logic                  tx_fs,
    output logic [4:0]            slot_idx,
    output logic [NUM_CH-1:0]     underrun,
    input  logic                  underrun_clr
);
    localparam logic [4:0] LAST_SLOT = 5'(NUM_CH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_next;
    logic [2:0]        bit_cnt;
    logic [4:0]        slot_cnt;
    logic [4:0]        slot_next;
    logic [6:0]        shreg;
    logic              load, shift, stop;
    logic [NUM_CH-1:0] load_ch;
    logic [NUM_CH-1:0] full;
    logic [12:0]       buf_q [NUM_CH];
    logic [12:0]       enc_in;
    logic [7:0]        enc_code;
    logic [7:0]        load_byte;

    assign ch_ready = ~full;

    // The one encoder in the design; its input follows the slot being entered.
    pcm_alaw u_pcm (
        .lin  (enc_in),
        .code (enc_code)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, slot sequencing and selection of the byte to load.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        stop       = 1'b0;
        slot_next  = slot_cnt;
        case (state)
            IDLE: begin
                if (bit_tick && en) begin
                    state_next = RUN;
                    load       = 1'b1;
                    slot_next  = 5'd0;
                end
            end
            RUN: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        if (slot_cnt == LAST_SLOT) begin
                            if (!en) begin
                                state_next = IDLE;
                                stop       = 1'b1;
                            end else begin
                                load      = 1'b1;
                                slot_next = 5'd0;
                            end
                        end else begin
                            load      = 1'b1;
                            slot_next = slot_cnt + 5'd1;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        enc_in  = '0;
        load_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_next == 5'(c + 1)) enc_in = buf_q[c];
            load_ch[c] = load && (slot_next == 5'(c + 1));
        end

        if (slot_next == 5'd0)        load_byte = FAS_WORD;
        else if (|(load_ch & full))   load_byte = enc_code;
        else                          load_byte = IDLE_CODE;
    end

    // Bit/slot counters and the serial output. The MSB goes straight to tx_bit,
    // while shreg keeps the seven bits still to be sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            slot_cnt <= 5'd0;
            shreg    <= 7'd0;
            tx_bit   <= 1'b0;
            tx_fs    <= 1'b0;
            slot_idx <= 5'd0;
        end else if (load) begin
            bit_cnt  <= 3'd0;
            slot_cnt <= slot_next;
            slot_idx <= slot_next;
            shreg    <= load_byte[6:0];
            tx_bit   <= load_byte[7];
            tx_fs    <= (slot_next == 5'd0);
        end else if (shift) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shreg    <= {shreg[5:0], 1'b0};
            tx_bit   <= shreg[6];
            tx_fs    <= 1'b0;
        end else if (stop) begin
            bit_cnt  <= 3'd0;
            slot_cnt <= 5'd0;
            slot_idx <= 5'd0;
            tx_bit   <= 1'b0;
            tx_fs    <= 1'b0;
        end
    end

    // Buffer occupancy and sticky underrun flags. A slot load that finds its
    // buffer empty flags underrun, and that flag takes priority over a clear in
    // the same cycle. A sample captured in that same cycle is held for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            underrun <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_ch[c] && full[c])       full[c] <= 1'b0;
                else if (ch_valid[c] && !full[c]) full[c] <= 1'b1;

                if (load_ch[c] && !full[c])      underrun[c] <= 1'b1;
                else if (underrun_clr)           underrun[c] <= 1'b0;
            end
        end
    end

    // Sample storage; the data only counts while the matching full bit is set.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid[c] && !full[c]) buf_q[c] <= ch_sample[13*c +: 13];
        end
    end
endmodule

// File: tb/tb_pcm_tdm_sched.sv
// Bench for pcm_tdm_sched. The stimulus thread queues the bytes expected in each
// frame. The monitor rebuilds bytes from tx_bit at every tick, aligned on tx_fs,
// and compares each byte against the front of the queue.
module tb_pcm_tdm_sched;
    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 bit_tick = 1'b0;
    logic                 underrun_clr = 1'b0;
    logic [13*NUM_CH-1:0] ch_sample = '0;
    logic [NUM_CH-1:0]    ch_valid = '0;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    underrun;
    logic                 tx_bit;
    logic                 tx_fs;
    logic [4:0]           slot_idx;

    int         tick_div = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         mon_on = 1'b0;
    logic [7:0] exp_q[$];

    pcm_tdm_sched #(.NUM_CH(NUM_CH), .FAS_WORD(8'h1B), .IDLE_CODE(8'hD5)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bit_tick     (bit_tick),
        .ch_sample    (ch_sample),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .tx_bit       (tx_bit),
        .tx_fs        (tx_fs),
        .slot_idx     (slot_idx),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(8'h1B);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    task automatic wait_slot(input logic [4:0] s, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (slot_idx === s) found = 1'b1;
        end
        check("wait_slot", 32'(found), 32'd1);
    endtask

    task automatic wait_fs(input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx_fs === 1'b1) found = 1'b1;
        end
        check("wait_fs", 32'(found), 32'd1);
    endtask

    task automatic clear_underrun();
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
    endtask

    // Bit tick generator: one tick every tick_div cycles (0 = no ticks).
    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (tick_div <= 0) bit_tick = 1'b0;
            else begin
                ph = (ph + 1) % tick_div;
                bit_tick = (ph == 0);
            end
        end
    end

    // Monitor: outputs hold between ticks; at each tick, bits are collected into bytes.
    initial begin : monitor
        logic       t, r;
        bit         coll;
        int         nb, sp;
        logic [7:0] acc;
        logic       p_bit, p_fs;
        logic [4:0] p_slot;
        coll = 1'b0; nb = 0; sp = 0; acc = '0;
        p_bit = 1'b0; p_fs = 1'b0; p_slot = '0;
        forever begin
            @(posedge clk);
            t = bit_tick;
            r = rst;
            #1;
            if (r) begin
                coll = 1'b0; nb = 0; sp = 0;
            end else if (!t) begin
                check("hold", {tx_fs, slot_idx, tx_bit}, {p_fs, p_slot, p_bit});
            end else if (mon_on) begin
                if (!coll && tx_fs === 1'b1) begin
                    coll = 1'b1; nb = 0; sp = 0;
                end
                if (coll) begin
                    check("fs_slot", {tx_fs, slot_idx}, {(sp == 0 && nb == 0), 5'(sp)});
                    acc = {acc[6:0], tx_bit};
                    nb++;
                    if (nb == 8) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_byte: got %0h expected none", acc);
                        end else begin
                            check("slot_byte", acc, exp_q.pop_front());
                        end
                        nb = 0;
                        sp++;
                        if (sp == NUM_CH + 1) coll = 1'b0;
                    end
                end
            end
            p_bit = tx_bit; p_fs = tx_fs; p_slot = slot_idx;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w, t;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_bit", tx_bit, 1'b0);
        check("rst_tx_fs", tx_fs, 1'b0);
        check("rst_slot", slot_idx, 5'd0);
        check("rst_ready", ch_ready, 4'hF);
        check("rst_underrun", underrun, 4'h0);
        rst = 1'b0;

        // Two frames with empty buffers, tick on every cycle; en dropped in slot 2
        tick_div = 1;
        mon_on = 1'b1;
        push_frame(8'hD5, 8'hD5, 8'hD5, 8'hD5);
        push_frame(8'hD5, 8'hD5, 8'hD5, 8'hD5);
        @(negedge clk);
        en = 1'b1;
        wait_slot(5'd2, 20);
        wait_fs(60);
        wait_slot(5'd2, 20);
        en = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_underrun", underrun, 4'hF);
        check("idle_out", {tx_bit, tx_fs, slot_idx}, 7'd0);
        clear_underrun();
        check("clr_underrun", underrun, 4'h0);

        // One frame with four buffered samples covering the encoder extremes
        @(negedge clk);
        ch_sample = {13'h1FFF, 13'h1000, 13'h0FFF, 13'h0000};
        ch_valid  = 4'hF;
        @(negedge clk);
        ch_valid  = 4'h0;
        check("ready_full", ch_ready, 4'h0);
        push_frame(8'hD5, 8'hAA, 8'h2A, 8'h55);
        en = 1'b1;
        wait_slot(5'd2, 30);
        check("ready_slot2", ch_ready, 4'b0011);
        en = 1'b0;
        wait_slot(5'd4, 30);
        check("ready_slot4", ch_ready, 4'hF);
        repeat (40) @(negedge clk);
        check("no_underrun", underrun, 4'h0);

        // Slow ticks: fs width and frame length measured in clock cycles
        tick_div = 4;
        push_frame(8'hD5, 8'hD5, 8'hD5, 8'hD5);
        push_frame(8'hD5, 8'hD5, 8'hD5, 8'hD5);
        en = 1'b1;
        wait_fs(20);
        w = 0;
        while (tx_fs === 1'b1 && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("fs_width", w, 4);
        t = w;
        do begin
            @(negedge clk);
            t++;
        end while (tx_fs !== 1'b1 && t < 400);
        check("frame_len", t, 160);
        wait_slot(5'd2, 200);
        en = 1'b0;
        repeat (200) @(negedge clk);
        check("slow_idle", {tx_bit, slot_idx}, 6'd0);
        check("slow_underrun", underrun, 4'hF);

        // Capture on the same tick that loads slot 2, together with underrun_clr
        tick_div = 1;
        clear_underrun();
        check("clr_underrun2", underrun, 4'h0);
        push_frame(8'hD5, 8'hD5, 8'hD5, 8'hD5);
        push_frame(8'hD5, 8'hAA, 8'hD5, 8'hD5);
        en = 1'b1;
        wait_slot(5'd1, 20);
        repeat (7) @(negedge clk);
        ch_sample[13 +: 13] = 13'h0FFF;
        ch_valid     = 4'b0010;
        underrun_clr = 1'b1;
        @(negedge clk);
        ch_valid     = 4'h0;
        underrun_clr = 1'b0;
        check("race_underrun", underrun, 4'b0010);
        check("race_ready", ch_ready, 4'b1101);
        check("race_slot", slot_idx, 5'd2);
        wait_fs(60);
        wait_slot(5'd2, 20);
        en = 1'b0;
        repeat (40) @(negedge clk);
        check("race_underrun_end", underrun, 4'hF);
        check("race_ready_end", ch_ready, 4'hF);

        // Reset in the middle of a slot discards buffered samples
        mon_on = 1'b0;
        clear_underrun();
        ch_sample[26 +: 13] = 13'h0123;
        ch_valid = 4'b0100;
        @(negedge clk);
        ch_valid = 4'h0;
        check("pre_rst_ready", ch_ready, 4'b1011);
        en = 1'b1;
        wait_slot(5'd1, 20);
        repeat (3) @(negedge clk);
        check("pre_rst_underrun", underrun, 4'b0001);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check("mid_rst_out", {tx_bit, tx_fs, slot_idx}, 7'd0);
        check("mid_rst_ready", ch_ready, 4'hF);
        check("mid_rst_underrun", underrun, 4'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {tx_bit, tx_fs, slot_idx}, 7'd0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
